fft_input_buffer: RTL and testbench
===================================

FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 The block SHALL have one parameter, N_LOG2, default 6: log2 of the frame length; the frame length is 64 points.
REQ-002 Port CLK SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 Port nRST SHALL be an input, 1 bit wide: the reset, which is asynchronous and active-low.
REQ-004 Port In_Data SHALL be an input, 32 bits wide: the complex input sample; [31:16] real and [15:0] imaginary, both 16-bit two's complement.
REQ-005 Port In_Valid SHALL be an input, 1 bit wide: the upstream sample is valid.
REQ-006 Port In_Ready SHALL be an output, 1 bit wide: the block accepts a sample this cycle.
REQ-007 Port Inverse SHALL be an input, 1 bit wide: 1 selects an IFFT frame; sampled on the first accepted sample of each frame.
REQ-008 Port Out_Data SHALL be an output, 32 bits wide: the complex sample fed to the downstream real/imaginary interchange stage, in the same packing as In_Data.
REQ-009 Port Out_Swap SHALL be an output, 1 bit wide: the swap control for the interchange stage; it equals the latched Inverse for the frame.
REQ-010 Port Out_Valid SHALL be an output, 1 bit wide: Out_Data is valid.
REQ-011 Port Out_Ready SHALL be an input, 1 bit wide: the downstream stage accepts Out_Data this cycle.
REQ-012 Port Out_Last SHALL be an output, 1 bit wide: marks the 64th output sample of a frame.
REQ-013 Port Busy SHALL be an output, 1 bit wide: high whenever the state is not LOAD or the write count is non-zero.

Function
REQ-014 The storage SHALL be a 64 x 32-bit register array, with a 6-bit write counter WCNT and a 6-bit read counter RCNT.
REQ-015 The FSM SHALL have exactly two states, LOAD and DRAIN.
REQ-016 In LOAD: In_Ready=1 and Out_Valid=0.
- An input handshake is In_Valid & In_Ready.
- Each handshake writes mem[WCNT] = In_Data and increments WCNT.
REQ-017 On a handshake with WCNT==0, Inverse SHALL be latched into a swap register; Out_Swap holds that value until the next frame's first handshake.
REQ-018 A handshake with WCNT==63 SHALL wrap WCNT to 0 and move the FSM to DRAIN.
- Out_Valid=1 from the next cycle.
- In_Ready=0 from the next cycle.
REQ-019 In DRAIN: In_Ready=0 and Out_Valid=1.
- Out_Data = mem[RMAP(RCNT)], a combinational read of the array.
- An output handshake is Out_Valid & Out_Ready.
- Each output handshake increments RCNT.
REQ-020 With Out_Ready=0 in DRAIN, Out_Data, Out_Last, Out_Swap and RCNT SHALL hold stable; there is no limit on stall length.
REQ-021 Out_Last SHALL equal (state==DRAIN && RCNT==63).
REQ-022 An output handshake with RCNT==63 SHALL wrap RCNT to 0 and move the FSM to LOAD.
- In_Ready=1 from the next cycle.
- No cycle exists where In_Ready and Out_Valid are both 1.
REQ-023 In_Valid while In_Ready=0 SHALL be ignored: no write, no counter change.
REQ-024 Data SHALL pass unmodified: no scaling, rounding or sign change.
REQ-025 Latency SHALL be as follows:
- The first output is valid 1 cycle after the 64th input handshake.
- With Out_Ready held at 1, a frame drains in 64 consecutive cycles.

Reset
REQ-026 While nRST=0, the block SHALL hold:
- state=LOAD, WCNT=0, RCNT=0, swap register=0;
- In_Ready=1, Out_Valid=0, Out_Last=0, Out_Swap=0, Busy=0.
REQ-027 Array contents SHALL NOT be reset; Out_Data is don't-care while Out_Valid=0.
REQ-028 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial frame.
- The first handshake after release is sample 0 of a new frame.
- Inverse is re-latched on that handshake.
REQ-029 Reset release SHALL take effect on the first rising CLK edge after nRST goes high.

Configuration
REQ-030 The macro FFT_INPUT_BITREV_EN SHALL select the read order.
- When defined: RMAP(RCNT) is RCNT bit-reversed over N_LOG2 bits, i.e. output order 0,32,16,48,8,... for a decimation-in-time core.
- When undefined: RMAP(RCNT) = RCNT, i.e. natural order.
- All handshake and timing behaviour is identical in both builds.

Verification
REQ-031 Reset then Inverse=0, 64 samples with In_Data=k<<16|k for k=0..63, Out_Ready=1 -> 64 outputs.
- With FFT_INPUT_BITREV_EN defined: outputs 0x00000000, 0x00200020, 0x00100010, ...
- With FFT_INPUT_BITREV_EN undefined: outputs 0x00000000, 0x00010001, ...
- In both builds: Out_Last only on output 63, Out_Swap=0.
REQ-032 Inverse=1 on sample 0, then Inverse=0 for samples 1..63 -> Out_Swap=1 throughout the drain; the next frame with Inverse=0 drives Out_Swap=0.
REQ-033 Out_Ready toggled 1/0 each cycle during DRAIN -> Out_Data stable during stalls, exactly 64 handshakes, In_Ready=0 until the cycle after the handshake on output 63.
REQ-034 In_Valid held at 1 with random data during DRAIN -> no array change; the next frame's contents match only the samples accepted in LOAD.
REQ-035 nRST pulsed low after 30 inputs (and, separately, after 10 outputs) -> outputs match reset values immediately, and a full frame is then accepted and drained correctly.

Source files
------------

// File: rtl/fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_buffer
// Brief    : 64-point frame buffer ahead of an FFT core; loads a full frame,
//            then drains it in natural or bit-reversed order with a swap flag.
//            Define FFT_INPUT_BITREV_EN for bit-reversed read order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_input_buffer #(
    parameter int N_LOG2 = 6
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] In_Data,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic        Inverse,
    output logic [31:0] Out_Data,
    output logic        Out_Swap,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic        Out_Last,
    output logic        Busy
);

    localparam int                c_depth    = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] c_last_idx = {N_LOG2{1'b1}};

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_LOG2-1:0]   wcnt_q, wcnt_d;
    logic [N_LOG2-1:0]   rcnt_q, rcnt_d;
    logic                swap_q, swap_d;
    logic [31:0]         mem_q [c_depth];

    logic                w_in_hs;
    logic                w_out_hs;
    logic [N_LOG2-1:0]   w_rmap;

    assign w_in_hs  = (state_q == LOAD)  && In_Valid;
    assign w_out_hs = (state_q == DRAIN) && Out_Ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        swap_d  = swap_q;
        if (w_in_hs) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == '0) begin
                swap_d = Inverse;
            end
            if (wcnt_q == c_last_idx) begin
                state_d = DRAIN;
            end
        end
        if (w_out_hs) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == c_last_idx) begin
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            swap_q  <= swap_d;
        end
    end

    // Sample storage is deliberately left unreset; reads are only valid in DRAIN.
    always_ff @(posedge CLK) begin
        if (w_in_hs) begin
            mem_q[wcnt_q] <= In_Data;
        end
    end

`ifdef FFT_INPUT_BITREV_EN
    for (genvar i = 0; i < N_LOG2; i++) begin : g_bitrev
        assign w_rmap[i] = rcnt_q[N_LOG2-1-i];
    end
`else
    assign w_rmap = rcnt_q;
`endif

    assign In_Ready  = (state_q == LOAD);
    assign Out_Valid = (state_q == DRAIN);
    assign Out_Last  = (state_q == DRAIN) && (rcnt_q == c_last_idx);
    assign Out_Swap  = swap_q;
    assign Out_Data  = mem_q[w_rmap];
    assign Busy      = (state_q != LOAD) || (wcnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_fft_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_buffer
// Brief    : Randomized self-checking bench for fft_input_buffer against a
//            frame-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_input_buffer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic        Inverse;
    logic [31:0] Out_Data;
    logic        Out_Swap;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Last;
    logic        Busy;

    int checks = 0;
    int passed = 0;

    logic [31:0] frame [64];
    logic        frame_inv;

    fft_input_buffer #(.N_LOG2(6)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .In_Data   (In_Data),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Inverse   (Inverse),
        .Out_Data  (Out_Data),
        .Out_Swap  (Out_Swap),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Last  (Out_Last),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    // Position in the frame that the i-th output should come from.
    function automatic int read_index(input int i);
`ifdef FFT_INPUT_BITREV_EN
        int r = 0;
        for (int b = 0; b < 6; b++) begin
            if (((i >> b) & 1) != 0) r = r + (1 << (5 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_frame(input int n, input logic inv0, input bit ramp, input bit bubbles);
        int k   = 0;
        int cyc = 0;
        while (k < n && cyc < 1000) begin
            In_Valid = bubbles ? ($urandom_range(3) != 0) : 1'b1;
            In_Data  = ramp ? {16'(k), 16'(k)} : $urandom;
            Inverse  = (k == 0) ? inv0 : ~inv0;
            checks++;
            if (In_Ready !== 1'b1 || Out_Valid !== 1'b0)
                $display("FAIL load_ready k=%0d: In_Ready=%b Out_Valid=%b, required 1/0",
                         k, In_Ready, Out_Valid);
            else
                passed++;
            if (In_Valid) begin
                frame[k] = In_Data;
                if (k == 0) frame_inv = inv0;
                k++;
            end
            tick();
            cyc++;
        end
        In_Valid = 1'b0;
        checks++;
        if (k != n || Busy !== 1'b1)
            $display("FAIL load_done: accepted=%0d Busy=%b, required %0d/1", k, Busy, n);
        else
            passed++;
    endtask

    task automatic drain_frame(input int n, input bit toggle, input bit noise);
        int i   = 0;
        int cyc = 0;
        logic [31:0] exp_data;
        while (i < n && cyc < 2000) begin
            Out_Ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (noise) begin
                In_Valid = 1'b1;
                In_Data  = $urandom;
                Inverse  = 1'($urandom_range(1));
            end
            exp_data = frame[read_index(i)];
            checks++;
            if (Out_Valid !== 1'b1 || In_Ready !== 1'b0 || Out_Data !== exp_data ||
                Out_Last !== (i == 63) || Out_Swap !== frame_inv || Busy !== 1'b1)
                $display("FAIL drain i=%0d: V=%b R=%b D=%h L=%b S=%b B=%b, required 1 0 %h %b %b 1",
                         i, Out_Valid, In_Ready, Out_Data, Out_Last, Out_Swap, Busy,
                         exp_data, (i == 63), frame_inv);
            else
                passed++;
            if (Out_Ready) i++;
            tick();
            cyc++;
        end
        Out_Ready = 1'b0;
        In_Valid  = 1'b0;
        checks++;
        if (i != n)
            $display("FAIL drain_count: handshakes=%0d, required %0d", i, n);
        else
            passed++;
        if (n == 64) begin
            checks++;
            if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Busy !== 1'b0 ||
                Out_Last !== 1'b0 || Out_Swap !== frame_inv)
                $display("FAIL drain_end: R=%b V=%b B=%b L=%b S=%b, required 1 0 0 0 %b",
                         In_Ready, Out_Valid, Busy, Out_Last, Out_Swap, frame_inv);
            else
                passed++;
        end
    endtask

    task automatic pulse_reset(input string tag);
        nRST     = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        #2;
        checks++;
        if (In_Ready !== 1'b1 || Out_Valid !== 1'b0 || Out_Last !== 1'b0 ||
            Out_Swap !== 1'b0 || Busy !== 1'b0)
            $display("FAIL %s: R=%b V=%b L=%b S=%b B=%b, required 1 0 0 0 0",
                     tag, In_Ready, Out_Valid, Out_Last, Out_Swap, Busy);
        else
            passed++;
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        nRST      = 1'b0;
        In_Valid  = 1'b0;
        In_Data   = '0;
        Inverse   = 1'b0;
        Out_Ready = 1'b0;
        tick();
        tick();
        checks++;
        if (In_Ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", In_Ready);
        else passed++;
        checks++;
        if (Out_Valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", Out_Valid);
        else passed++;
        checks++;
        if (Out_Last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", Out_Last);
        else passed++;
        checks++;
        if (Out_Swap !== 1'b0) $display("FAIL reset_out_swap: got %b, required 0", Out_Swap);
        else passed++;
        checks++;
        if (Busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", Busy);
        else passed++;
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_ramp;
        load_frame(64, 1'b0, 1'b1, 1'b0);
        checks++;
        if (Out_Valid !== 1'b1 || Out_Data !== 32'h0000_0000)
            $display("FAIL ramp_first: V=%b D=%h, required 1 00000000", Out_Valid, Out_Data);
        else
            passed++;
        drain_frame(64, 1'b0, 1'b0);
    endtask

    task automatic test_inverse;
        load_frame(64, 1'b1, 1'b0, 1'b1);
        drain_frame(64, 1'b0, 1'b0);
        load_frame(64, 1'b0, 1'b0, 1'b1);
        drain_frame(64, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        load_frame(64, 1'($urandom_range(1)), 1'b0, 1'b1);
        drain_frame(64, 1'b1, 1'b0);
    endtask

    task automatic test_drain_noise;
        load_frame(64, 1'b1, 1'b0, 1'b0);
        drain_frame(64, 1'b1, 1'b1);
        load_frame(64, 1'b0, 1'b0, 1'b1);
        drain_frame(64, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        load_frame(30, 1'b0, 1'b0, 1'b0);
        pulse_reset("reset_mid_load");
        load_frame(64, 1'b1, 1'b0, 1'b1);
        drain_frame(64, 1'b0, 1'b0);
        load_frame(64, 1'b1, 1'b0, 1'b0);
        drain_frame(10, 1'b0, 1'b0);
        pulse_reset("reset_mid_drain");
        load_frame(64, 1'b0, 1'b0, 1'b1);
        drain_frame(64, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) begin
            load_frame(64, 1'($urandom_range(1)), 1'b0, 1'b0);
            drain_frame(64, 1'b0, 1'b0);
        end
    endtask

    initial begin
        frame_inv = 1'b0;
        test_reset();
        test_ramp();
        test_inverse();
        test_stall();
        test_drain_noise();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
